// File: rtl/alu_pkg.sv
// Shared types and constants for the 32-bit ALU and its two-port arbiter.
package alu_pkg;

   localparam int unsigned ALU_W = 32;
   localparam int unsigned SEL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [SEL_W-1:0] SEL_ADD = 3'd0;
   localparam logic [SEL_W-1:0] SEL_SUB = 3'd1;
   localparam logic [SEL_W-1:0] SEL_AND = 3'd2;
   localparam logic [SEL_W-1:0] SEL_OR  = 3'd3;
   localparam logic [SEL_W-1:0] SEL_XOR = 3'd4;
   localparam logic [SEL_W-1:0] SEL_NOT = 3'd5;
   localparam logic [SEL_W-1:0] SEL_SHL = 3'd6;
   localparam logic [SEL_W-1:0] SEL_SHR = 3'd7;

   typedef struct packed {
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
      logic [SEL_W-1:0] sel;
   } alu_req_t;

   typedef struct packed {
      logic [ALU_W-1:0] out;
      logic             c;
      logic             z;
      logic             n;
   } alu_rsp_t;

endpackage

// File: rtl/alu_32bit.sv
// Combinational 32-bit ALU: add/sub with carry/borrow, logic ops, 1-bit shifts; z/n from result.
module alu_32bit
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [SEL_W-1:0] sel,
   output logic [ALU_W-1:0] out,
   output logic             c,
   output logic             z,
   output logic             n
);

   logic [ALU_W:0] ext;

   // Bit ALU_W carries the carry (add), borrow (sub) or shifted-out bit.
   always_comb begin
      ext = '0;
      case (sel)
         SEL_ADD: ext = {1'b0, a} + {1'b0, b};
         SEL_SUB: ext = {1'b0, a} - {1'b0, b};
         SEL_AND: ext = {1'b0, a & b};
         SEL_OR:  ext = {1'b0, a | b};
         SEL_XOR: ext = {1'b0, a ^ b};
         SEL_NOT: ext = {1'b0, ~a};
         SEL_SHL: ext = {a, 1'b0};
         SEL_SHR: ext = {a[0], 1'b0, a[ALU_W-1:1]};
         default: ext = '0;
      endcase
   end

   assign out = ext[ALU_W-1:0];
   assign c   = ext[ALU_W];
   assign z   = (out == '0);
   assign n   = out[ALU_W-1];

endmodule

// File: rtl/alu_32bit_arbiter.sv
// Shares one alu_32bit between two valid/ready requester ports; one operation in flight at a time.
module alu_32bit_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned RR_EN = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             p0_req_valid,
   output logic             p0_req_ready,
   input  logic [ALU_W-1:0] p0_a,
   input  logic [ALU_W-1:0] p0_b,
   input  logic [SEL_W-1:0] p0_sel,
   output logic             p0_rsp_valid,
   input  logic             p0_rsp_ready,
   input  logic             p1_req_valid,
   output logic             p1_req_ready,
   input  logic [ALU_W-1:0] p1_a,
   input  logic [ALU_W-1:0] p1_b,
   input  logic [SEL_W-1:0] p1_sel,
   output logic             p1_rsp_valid,
   input  logic             p1_rsp_ready,
   output logic [ALU_W-1:0] rsp_out,
   output logic             rsp_c,
   output logic             rsp_z,
   output logic             rsp_n,
   output logic             busy,
   output logic [CNT_W-1:0] op_cnt
);

   state_t           state_q, state_d;
   alu_req_t         op_q;
   alu_rsp_t         rsp_q;
   logic             owner_q;
   logic             rr_last_q;
   logic [CNT_W-1:0] cnt_q;

   logic [1:0]       grant;
   logic [1:0]       ready;
   logic [1:0]       rsp_valid;
   logic             complete;

   logic [ALU_W-1:0] alu_out;
   logic             alu_c, alu_z, alu_n;

   alu_32bit u_alu (
      .a   (op_q.a),
      .b   (op_q.b),
      .sel (op_q.sel),
      .out (alu_out),
      .c   (alu_c),
      .z   (alu_z),
      .n   (alu_n)
   );

   // Contention goes to the port that did not complete last (or always p0 without round-robin).
   always_comb begin
      grant = 2'b00;
      if (p0_req_valid && p1_req_valid) begin
         if ((RR_EN != 0) && !rr_last_q) grant = 2'b10;
         else                            grant = 2'b01;
      end else begin
         grant = {p1_req_valid, p0_req_valid};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Ready is masked during reset so nothing is offered while the block is held idle.
   always_comb begin
      state_d   = state_q;
      ready     = 2'b00;
      rsp_valid = 2'b00;
      complete  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = grant & {2{rst_n}};
            if (ready != 2'b00) state_d = ST_EXEC;
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
            if (owner_q ? p1_rsp_ready : p0_rsp_ready) begin
               state_d  = ST_IDLE;
               complete = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         owner_q   <= 1'b0;
         rsp_q     <= '0;
         cnt_q     <= '0;
         rr_last_q <= 1'b1;
      end else begin
         if (ready[1]) begin
            op_q    <= '{a: p1_a, b: p1_b, sel: p1_sel};
            owner_q <= 1'b1;
         end else if (ready[0]) begin
            op_q    <= '{a: p0_a, b: p0_b, sel: p0_sel};
            owner_q <= 1'b0;
         end
         if (state_q == ST_EXEC) rsp_q <= '{out: alu_out, c: alu_c, z: alu_z, n: alu_n};
         if (complete) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            rr_last_q <= owner_q;
         end
      end
   end

   assign p0_req_ready = ready[0];
   assign p1_req_ready = ready[1];
   assign p0_rsp_valid = rsp_valid[0];
   assign p1_rsp_valid = rsp_valid[1];
   assign rsp_out      = rsp_q.out;
   assign rsp_c        = rsp_q.c;
   assign rsp_z        = rsp_q.z;
   assign rsp_n        = rsp_q.n;
   assign busy         = (state_q != ST_IDLE);
   assign op_cnt       = cnt_q;

endmodule
